// File: rtl/pixel_write_buffer_if.sv
// Pixel-in / SDRAM-write-out handshake bundle for pixel_write_buffer.
// master = rasterizer + SDRAM controller side, slave = the buffer.
interface pixel_write_buffer_if #(
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 9,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 23
);
  logic              pix_valid;
  logic              pix_ready;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [DATA_W-1:0] pix_color;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, wr_ack,
    input  pix_ready, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, wr_ack,
    output pix_ready, wr_req, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_write_buffer.sv
// Clips rasterizer pixels to the screen, forms SDRAM word addresses for the selected frame
// and drains address/data pairs to the SDRAM controller through a FIFO with req/ack.
module pixel_write_buffer #(
  parameter int unsigned       H_RES       = 640,
  parameter int unsigned       V_RES       = 480,
  parameter int unsigned       X_W         = 10,
  parameter int unsigned       Y_W         = 9,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] FRAME1_BASE = 23'h000000,
  parameter logic [ADDR_W-1:0] FRAME2_BASE = 23'h080000,
  parameter int unsigned       DEPTH       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_target,
  pixel_write_buffer_if.slave  bus,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned       PtrW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] HResA = ADDR_W'(H_RES);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              accept;
  logic              on_screen;
  logic [ADDR_W-1:0] pix_addr;

  logic              stage_valid_q;
  logic [ADDR_W-1:0] stage_addr_q;
  logic [DATA_W-1:0] stage_data_q;
  logic [7:0]        drop_cnt_q;

  logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]          wptr_q, rptr_q;
  logic [PtrW:0]            count_q;
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ADDR_W+DATA_W-1:0] fifo_head;

  state_e            state_q;
  logic              wr_req_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  assign pix_x     = bus.pix_x;
  assign pix_y     = bus.pix_y;
  assign on_screen = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  assign accept    = bus.pix_valid && bus.pix_ready;
  // frame_target is sampled with the pixel, so later swaps never retarget it
  assign pix_addr  = (frame_target ? FRAME1_BASE : FRAME2_BASE)
                   + ADDR_W'(pix_y) * HResA + ADDR_W'(pix_x);

  assign fifo_full  = (count_q == (PtrW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_push  = stage_valid_q && !fifo_full;
  assign fifo_pop   = !fifo_empty && ((state_q == StIdle) || bus.wr_ack);
  assign fifo_head  = mem_q[rptr_q];

  // Registered state only: a pop on this edge does not free a slot until the next cycle
  assign bus.pix_ready = !(stage_valid_q && fifo_full);
  assign bus.wr_req    = wr_req_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign busy          = !fifo_empty || stage_valid_q || wr_req_q;
  assign drop_cnt      = drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (accept && on_screen) begin
        stage_valid_q <= 1'b1;
        stage_addr_q  <= pix_addr;
        stage_data_q  <= bus.pix_color;
      end else if (fifo_push) begin
        stage_valid_q <= 1'b0;
      end
      if (accept && !on_screen && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_q[wptr_q] <= {stage_addr_q, stage_data_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (fifo_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (fifo_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            {wr_addr_q, wr_data_q} <= fifo_head;
            wr_req_q               <= 1'b1;
            state_q                <= StReq;
          end
        end
        StReq: begin
          if (bus.wr_ack) begin
            if (!fifo_empty) begin
              {wr_addr_q, wr_data_q} <= fifo_head;
            end else begin
              wr_req_q <= 1'b0;
              state_q  <= StIdle;
            end
          end
        end
        default: begin
          wr_req_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed self-checking bench for pixel_write_buffer.
module tb_pixel_write_buffer;

  localparam int unsigned DEPTH = 8;

  logic       clk;
  logic       reset;
  logic       frame_target;
  logic       busy;
  logic [7:0] drop_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  logic [22:0] got_addr[$];
  logic [15:0] got_data[$];
  int          got_cyc[$];

  pixel_write_buffer_if bus ();

  pixel_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_target (frame_target),
    .bus          (bus),
    .busy         (busy),
    .drop_cnt     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every completed write (req and ack both high at an edge)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset === 1'b0 && bus.wr_req === 1'b1 && bus.wr_ack === 1'b1) begin
      got_addr.push_back(bus.wr_addr);
      got_data.push_back(bus.wr_data);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [22:0] exp_addr(input logic ft, input int x, input int y);
    int unsigned a;
    a = (ft ? 32'h0 : 32'h80000) + 32'(y) * 640 + 32'(x);
    return a[22:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  // Offers a pixel and returns 1ns after the edge that accepted it; pix_valid is left high
  task automatic send_pix(input int x, input int y, input logic [15:0] c, input logic ft);
    int waited = 0;
    frame_target  = ft;
    bus.pix_valid = 1'b1;
    bus.pix_x     = 10'(x);
    bus.pix_y     = 9'(y);
    bus.pix_color = c;
    while (bus.pix_ready !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    if (bus.pix_ready !== 1'b1) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL send_pix_timeout: pix_ready=%b after %0d cycles, want 1", bus.pix_ready,
               waited);
    end
    tick();
  endtask

  task automatic idle_pix();
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_drain: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b0 || busy !== 1'b0 || bus.pix_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL por_flags: wr_req=%b busy=%b pix_ready=%b, want 0 0 1", bus.wr_req, busy,
               bus.pix_ready);
    end
    vec_cnt++;
    if (bus.wr_addr !== 23'h0 || bus.wr_data !== 16'h0 || drop_cnt !== 8'd0) begin
      err_cnt++;
      $display("FAIL por_values: wr_addr=%h wr_data=%h drop_cnt=%0d, want 0 0 0", bus.wr_addr,
               bus.wr_data, drop_cnt);
    end
    reset = 1'b0;
    tick();
    // Build up a burst with a drop, a request in flight and entries queued
    bus.wr_ack = 1'b0;
    send_pix(700, 0, 16'h0BAD, 1'b1);
    send_pix(1, 1, 16'h1111, 1'b1);
    send_pix(2, 1, 16'h2222, 1'b1);
    send_pix(3, 1, 16'h3333, 1'b1);
    idle_pix();
    vec_cnt++;
    if (busy !== 1'b1 || bus.wr_req !== 1'b1 || drop_cnt !== 8'd1) begin
      err_cnt++;
      $display("FAIL burst_setup: busy=%b wr_req=%b drop_cnt=%0d, want 1 1 1", busy, bus.wr_req,
               drop_cnt);
    end
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (bus.wr_req !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0 || bus.pix_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL async_reset: wr_req=%b busy=%b drop_cnt=%0d pix_ready=%b, want 0 0 0 1",
               bus.wr_req, busy, drop_cnt, bus.pix_ready);
    end
    tick();
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_discard: wr_req=%b busy=%b, want 0 0", bus.wr_req, busy);
    end
  endtask

  task automatic test_address();
    bus.wr_ack = 1'b0;
    send_pix(5, 2, 16'hABCD, 1'b1);
    idle_pix();
    vec_cnt++;
    if (bus.wr_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_n: wr_req=%b one edge after accept, want 0", bus.wr_req);
    end
    tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_n1: wr_req=%b two edges after accept, want 0", bus.wr_req);
    end
    tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b1 || bus.wr_addr !== 23'h000505 || bus.wr_data !== 16'hABCD) begin
      err_cnt++;
      $display("FAIL addr_frame1: wr_req=%b addr=%h data=%h, want 1 000505 abcd", bus.wr_req,
               bus.wr_addr, bus.wr_data);
    end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    vec_cnt++;
    if (bus.wr_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL ack_release: wr_req=%b, want 0", bus.wr_req);
    end
    send_pix(5, 2, 16'hABCD, 1'b0);
    idle_pix();
    tick();
    tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b1 || bus.wr_addr !== 23'h080505 || bus.wr_data !== 16'hABCD) begin
      err_cnt++;
      $display("FAIL addr_frame2: wr_req=%b addr=%h data=%h, want 1 080505 abcd", bus.wr_req,
               bus.wr_addr, bus.wr_data);
    end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    // Last on-screen pixel of frame 2
    send_pix(639, 479, 16'hFFFF, 1'b0);
    idle_pix();
    tick();
    tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b1 || bus.wr_addr !== 23'h0CAFFF || bus.wr_data !== 16'hFFFF) begin
      err_cnt++;
      $display("FAIL addr_corner: wr_req=%b addr=%h data=%h, want 1 0cafff ffff", bus.wr_req,
               bus.wr_addr, bus.wr_data);
    end
    bus.wr_ack = 1'b1;
    tick();
    tick();
    tick();
    bus.wr_ack = 1'b0;
    vec_cnt++;
    if (bus.wr_req !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_ack_ignored: wr_req=%b busy=%b, want 0 0", bus.wr_req, busy);
    end
  endtask

  task automatic test_handshake();
    bus.wr_ack = 1'b0;
    send_pix(7, 3, 16'h1234, 1'b1);
    send_pix(8, 3, 16'h5678, 1'b1);
    idle_pix();
    tick();
    for (int i = 0; i < 11; i++) begin
      vec_cnt++;
      if (bus.wr_req !== 1'b1 || bus.wr_addr !== 23'h000787 || bus.wr_data !== 16'h1234) begin
        err_cnt++;
        $display("FAIL hold_cycle%0d: wr_req=%b addr=%h data=%h, want 1 000787 1234", i,
                 bus.wr_req, bus.wr_addr, bus.wr_data);
      end
      if (i < 10) tick();
    end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if (bus.wr_req !== 1'b1 || bus.wr_addr !== 23'h000788 || bus.wr_data !== 16'h5678) begin
      err_cnt++;
      $display("FAIL one_ack_one_pop: wr_req=%b addr=%h data=%h, want 1 000788 5678", bus.wr_req,
               bus.wr_addr, bus.wr_data);
    end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    vec_cnt++;
    if (bus.wr_req !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL handshake_empty: wr_req=%b busy=%b, want 0 0", bus.wr_req, busy);
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    clear_log();
    bus.wr_ack = 1'b0;
    while (n_acc < DEPTH + 3 && bus.pix_ready === 1'b1) begin
      frame_target  = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_x     = 10'(3 * n_acc + 1);
      bus.pix_y     = 9'(n_acc + 20);
      bus.pix_color = 16'h1000 + 16'(n_acc);
      tick();
      n_acc++;
    end
    // One pixel sits on the write port; DEPTH+1 more fill the FIFO and address stage
    vec_cnt++;
    if (n_acc != DEPTH + 2) begin
      err_cnt++;
      $display("FAIL full_count: accepted %0d before stall, want %0d", n_acc, DEPTH + 2);
    end
    repeat (3) tick();
    vec_cnt++;
    if (bus.pix_ready !== 1'b0 || bus.wr_req !== 1'b1 || bus.wr_addr !== exp_addr(1'b1, 1, 20))
    begin
      err_cnt++;
      $display("FAIL stall_hold: pix_ready=%b wr_req=%b addr=%h, want 0 1 %h", bus.pix_ready,
               bus.wr_req, bus.wr_addr, exp_addr(1'b1, 1, 20));
    end
    bus.wr_ack = 1'b1;
    for (int i = n_acc; i < DEPTH + 3; i++) begin
      send_pix(3 * i + 1, i + 20, 16'h1000 + 16'(i), 1'b1);
    end
    idle_pix();
    wait_idle("backpressure");
    bus.wr_ack = 1'b0;
    vec_cnt++;
    if (got_addr.size() != DEPTH + 3) begin
      err_cnt++;
      $display("FAIL drain_count: %0d writes, want %0d", got_addr.size(), DEPTH + 3);
    end else begin
      for (int i = 0; i < DEPTH + 3; i++) begin
        vec_cnt++;
        if (got_addr[i] !== exp_addr(1'b1, 3 * i + 1, i + 20) ||
            got_data[i] !== 16'h1000 + 16'(i)) begin
          err_cnt++;
          $display("FAIL drain_order%0d: addr=%h data=%h, want %h %h", i, got_addr[i],
                   got_data[i], exp_addr(1'b1, 3 * i + 1, i + 20), 16'h1000 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_drops();
    logic seen = 1'b0;
    clear_log();
    bus.wr_ack = 1'b0;
    send_pix(640, 0, 16'hDEAD, 1'b1);
    send_pix(0, 480, 16'hBEEF, 1'b1);
    idle_pix();
    repeat (4) begin
      if (bus.wr_req !== 1'b0) seen = 1'b1;
      tick();
    end
    vec_cnt++;
    if (seen !== 1'b0 || drop_cnt !== 8'd2 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL drop_edges: saw_req=%b drop_cnt=%0d busy=%b, want 0 2 0", seen, drop_cnt,
               busy);
    end
    for (int i = 0; i < 253; i++) send_pix(640 + (i % 384), i % 512, 16'(i), i[0]);
    vec_cnt++;
    if (drop_cnt !== 8'd255) begin
      err_cnt++;
      $display("FAIL drop_255: drop_cnt=%0d, want 255", drop_cnt);
    end
    for (int i = 253; i < 300; i++) send_pix(640 + (i % 384), i % 512, 16'(i), i[0]);
    idle_pix();
    tick();
    vec_cnt++;
    if (drop_cnt !== 8'd255 || bus.wr_req !== 1'b0 || got_addr.size() != 0) begin
      err_cnt++;
      $display("FAIL drop_saturate: drop_cnt=%0d wr_req=%b writes=%0d, want 255 0 0", drop_cnt,
               bus.wr_req, got_addr.size());
    end
  endtask

  task automatic test_frame_swap();
    clear_log();
    bus.wr_ack = 1'b1;
    for (int i = 0; i < 8; i++) send_pix(4 * i, 100 + i, 16'h6000 + 16'(i), (i < 4));
    idle_pix();
    wait_idle("frame_swap");
    bus.wr_ack = 1'b0;
    vec_cnt++;
    if (got_addr.size() != 8) begin
      err_cnt++;
      $display("FAIL swap_count: %0d writes, want 8", got_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vec_cnt++;
        if (got_addr[i] !== exp_addr(i < 4, 4 * i, 100 + i) ||
            got_data[i] !== 16'h6000 + 16'(i)) begin
          err_cnt++;
          $display("FAIL swap_entry%0d: addr=%h data=%h, want %h %h", i, got_addr[i],
                   got_data[i], exp_addr(i < 4, 4 * i, 100 + i), 16'h6000 + 16'(i));
        end
      end
      vec_cnt++;
      if (got_cyc[7] - got_cyc[0] != 7) begin
        err_cnt++;
        $display("FAIL back_to_back: 8 writes spanned %0d cycles, want 7",
                 got_cyc[7] - got_cyc[0]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    frame_target  = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_x     = '0;
    bus.pix_y     = '0;
    bus.pix_color = '0;
    bus.wr_ack    = 1'b0;
    test_reset();
    test_address();
    test_handshake();
    test_backpressure();
    test_drops();
    test_frame_swap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
